// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch time base: 1 Hz count prescaler, 2 Hz adjust/blink prescaler, pause toggle.
// Define STOPWATCH_DEBOUNCE_EN to insert a debounce stage on the synchronized pause button.
`timescale 1ns/1ps
module stopwatch_counter #(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned ADJ_DIV         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       fastClk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic       sel,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       paused,
  output logic       blinkClk,
  output logic       tick_1hz
);

  localparam int unsigned P1W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned P2W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [P1W-1:0] P1Max = P1W'(TICK_DIV - 1);
  localparam logic [P2W-1:0] P2Max = P2W'(ADJ_DIV - 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  logic [P1W-1:0] p1_q, p1_d;
  logic [P2W-1:0] p2_q, p2_d;
  logic [5:0]     min_q, min_d;
  logic [5:0]     sec_q, sec_d;
  logic           paused_q, paused_d;
  logic           blink_q, blink_d;
  logic           tick_q, tick_d;
  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           lvl_prev_q, lvl_prev_d;
  logic           lvl;
  logic           press;
  logic           tick_2hz;
  logic           run;
  logic           p1_wrap;

`ifdef STOPWATCH_DEBOUNCE_EN
  logic           lvl_q, lvl_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  // Accept a new level only after it has disagreed with the current one for the full window.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (db_cnt_q == DbMax) begin
        lvl_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge fastClk or posedge reset) begin
    if (reset) begin
      lvl_q    <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  logic unused_db;
  assign unused_db = ^DbMax;
  assign lvl       = s2_q;
`endif

  always_comb begin
    s1_d       = btn_pause;
    s2_d       = s1_q;
    lvl_prev_d = lvl;
    press      = lvl & ~lvl_prev_q;
    paused_d   = press ? ~paused_q : paused_q;

    tick_2hz = (p2_q == P2Max);
    p2_d     = tick_2hz ? '0 : p2_q + P2W'(1);
    blink_d  = tick_2hz ? ~blink_q : blink_q;

    // Counting uses the pre-toggle paused value, so a coincident press still counts.
    run     = ~adj & ~paused_q;
    p1_wrap = run && (p1_q == P1Max);
    tick_d  = p1_wrap;

    p1_d  = p1_q;
    min_d = min_q;
    sec_d = sec_q;
    if (adj) begin
      if (tick_2hz) begin
        if (sel) begin
          sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end else begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
    end else if (run) begin
      if (p1_wrap) begin
        p1_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        p1_d = p1_q + P1W'(1);
      end
    end
  end

  always_ff @(posedge fastClk or posedge reset) begin
    if (reset) begin
      p1_q       <= '0;
      p2_q       <= '0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      paused_q   <= 1'b0;
      blink_q    <= 1'b0;
      tick_q     <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      paused_q   <= paused_d;
      blink_q    <= blink_d;
      tick_q     <= tick_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lvl_prev_q <= lvl_prev_d;
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign paused   = paused_q;
  assign blinkClk = blink_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with small dividers; follows STOPWATCH_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  localparam int unsigned TickDiv  = 10;
  localparam int unsigned AdjDiv   = 5;
  localparam int unsigned DbCycles = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int PressLat = 3 + DbCycles;
  localparam bit DbEn     = 1'b1;
`else
  localparam int PressLat = 3;
  localparam bit DbEn     = 1'b0;
`endif

  logic       fastClk;
  logic       reset;
  logic       btn_pause;
  logic       adj;
  logic       sel;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       paused;
  logic       blinkClk;
  logic       tick_1hz;

  stopwatch_counter #(
    .TICK_DIV       (TickDiv),
    .ADJ_DIV        (AdjDiv),
    .DEBOUNCE_CYCLES(DbCycles)
  ) dut (
    .fastClk  (fastClk),
    .reset    (reset),
    .btn_pause(btn_pause),
    .adj      (adj),
    .sel      (sel),
    .minutes  (minutes),
    .seconds  (seconds),
    .paused   (paused),
    .blinkClk (blinkClk),
    .tick_1hz (tick_1hz)
  );

  initial fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];
  int em = 0;
  int es = 0;

  task automatic step();
    @(posedge fastClk);
    #1;
  endtask

  // Expected mm:ss after each of the next n counted seconds.
  function automatic void push_run(int n);
    for (int i = 0; i < n; i++) begin
      es++;
      if (es == 60) begin
        es = 0;
        em = (em == 59) ? 0 : em + 1;
      end
      exp_q.push_back({6'(em), 6'(es)});
    end
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if ({minutes, seconds, paused, blinkClk, tick_1hz} !== 15'd0)
      $display("FAIL reset_state got %0d:%0d p=%b b=%b t=%b want all 0",
               minutes, seconds, paused, blinkClk, tick_1hz);
    else n_pass++;
    @(negedge fastClk);
    reset = 1'b0;
  endtask

  task automatic test_run();
    int pulses = 0;
    int phase_err = 0;
    logic [11:0] e;
    push_run(60);
    for (int k = 1; k <= 600; k++) begin
      step();
      if (tick_1hz === 1'b1) begin
        pulses++;
        if (k % 10 != 0) phase_err++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL run_tick got unexpected tick want none");
        else begin
          e = exp_q.pop_front();
          if ({minutes, seconds} !== e)
            $display("FAIL run_tick got %0d:%0d want %0d:%0d", minutes, seconds, e[11:6], e[5:0]);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (pulses != 60 || phase_err != 0)
      $display("FAIL run_pulses got %0d (phase errs %0d) want 60 (0)", pulses, phase_err);
    else n_pass++;
    n_checks++;
    if ({minutes, seconds, paused} !== {6'd1, 6'd0, 1'b0})
      $display("FAIL run_end got %0d:%0d p=%b want 1:0 p=0", minutes, seconds, paused);
    else n_pass++;
  endtask

  task automatic test_preload_wrap();
    int k = 0;
    int err = 0;
    int pulses = 0;
    int at = 0;
    logic [11:0] e;
    adj = 1'b1;
    sel = 1'b0;
    while (minutes !== 6'd59 && k < 400) begin
      step();
      k++;
      if (tick_1hz !== 1'b0 || seconds !== 6'd0) err++;
    end
    sel = 1'b1;
    k = 0;
    while (seconds !== 6'd59 && k < 400) begin
      step();
      k++;
      if (tick_1hz !== 1'b0 || minutes !== 6'd59) err++;
    end
    n_checks++;
    if ({minutes, seconds} !== {6'd59, 6'd59} || err != 0)
      $display("FAIL preload got %0d:%0d errs %0d want 59:59 errs 0", minutes, seconds, err);
    else n_pass++;
    adj = 1'b0;
    em = 59;
    es = 59;
    push_run(1);
    for (int j = 1; j <= 10; j++) begin
      step();
      if (tick_1hz === 1'b1) begin
        pulses++;
        at = j;
        n_checks++;
        e = exp_q.pop_front();
        if ({minutes, seconds} !== e)
          $display("FAIL full_wrap got %0d:%0d want %0d:%0d", minutes, seconds, e[11:6], e[5:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 1 || at != 10)
      $display("FAIL wrap_timing got %0d pulses at %0d want 1 at 10", pulses, at);
    else n_pass++;
  endtask

  task automatic test_adjust_fields();
    int toggles;
    int err = 0;
    int last_t = 0;
    int sp_err = 0;
    logic prev;
    logic [11:0] e;
    push_run(58);
    for (int k = 1; k <= 580; k++) begin
      step();
      if (tick_1hz === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        if ({minutes, seconds} !== e) err++;
      end
    end
    n_checks++;
    if (err != 0 || exp_q.size() != 0 || seconds !== 6'd58)
      $display("FAIL run_to_58 got sec %0d errs %0d left %0d want 58 0 0",
               seconds, err, exp_q.size());
    else n_pass++;
    adj = 1'b1;
    sel = 1'b1;
    exp_q.push_back({6'd0, 6'd59});
    exp_q.push_back({6'd0, 6'd0});
    exp_q.push_back({6'd0, 6'd1});
    exp_q.push_back({6'd1, 6'd1});
    exp_q.push_back({6'd2, 6'd1});
    exp_q.push_back({6'd3, 6'd1});
    for (int phase = 0; phase < 2; phase++) begin
      sel = (phase == 0);
      toggles = 0;
      prev = blinkClk;
      err = 0;
      for (int k = 1; k <= 15; k++) begin
        step();
        if (tick_1hz !== 1'b0) err++;
        if (blinkClk !== prev) begin
          prev = blinkClk;
          toggles++;
          if (phase == 1 && last_t != 0 && k - last_t != 5) sp_err++;
          last_t = k;
          n_checks++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
          if ({minutes, seconds} !== e)
            $display("FAIL adjust_step got %0d:%0d want %0d:%0d",
                     minutes, seconds, e[11:6], e[5:0]);
          else n_pass++;
        end
      end
      n_checks++;
      if (toggles != 3 || err != 0)
        $display("FAIL adjust_phase%0d got %0d steps %0d ticks want 3 0", phase, toggles, err);
      else n_pass++;
      last_t = 0;
    end
    n_checks++;
    if (sp_err != 0) $display("FAIL minute_spacing got %0d errs want 0", sp_err);
    else n_pass++;
    adj = 1'b0;
    em = 3;
    es = 1;
  endtask

  task automatic test_pause();
    int s0 = (16 - PressLat) % 10;
    int pe = 0;
    int he = 0;
    int re = 0;
    int first = 0;
    logic [11:0] e;
    push_run((s0 + PressLat) / 10);
    for (int k = 1; k <= s0 + PressLat; k++) begin
      step();
      if (paused !== (k == s0 + PressLat)) pe++;
      if (tick_1hz === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        if ({minutes, seconds} !== e) pe++;
      end
      if (k == s0) btn_pause = 1'b1;
    end
    n_checks++;
    if (pe != 0 || exp_q.size() != 0)
      $display("FAIL pause_entry got %0d errs want 0", pe);
    else n_pass++;
    btn_pause = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (paused !== 1'b1 || tick_1hz !== 1'b0 || {minutes, seconds} !== {6'(em), 6'(es)}) he++;
    end
    n_checks++;
    if (he != 0) $display("FAIL pause_hold got %0d changed cycles want 0", he);
    else n_pass++;
    btn_pause = 1'b1;
    for (int k = 1; k <= PressLat; k++) begin
      step();
      if (paused !== (k < PressLat) || tick_1hz !== 1'b0) re++;
    end
    n_checks++;
    if (re != 0) $display("FAIL resume_toggle got %0d errs want 0", re);
    else n_pass++;
    push_run(3);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (tick_1hz === 1'b1) begin
        if (first == 0) first = k;
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        if ({minutes, seconds} !== e)
          $display("FAIL resume_tick got %0d:%0d want %0d:%0d", minutes, seconds, e[11:6], e[5:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (first != 4 || paused !== 1'b0 || exp_q.size() != 0)
      $display("FAIL resume_latency got first %0d p=%b want 4 p=0", first, paused);
    else n_pass++;
    btn_pause = 1'b0;
  endtask

  task automatic test_debounce();
    logic exp_p = DbEn ? 1'b0 : 1'b1;
    int te = 0;
    adj = 1'b1;
    for (int k = 0; k < PressLat + 3; k++) step();
    n_checks++;
    if (paused !== 1'b0) $display("FAIL db_idle got %b want 0", paused);
    else n_pass++;
    btn_pause = 1'b1;
    for (int k = 0; k < 3; k++) step();
    btn_pause = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (paused !== exp_p) $display("FAIL short_pulse got %b want %b", paused, exp_p);
    else n_pass++;
    btn_pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (paused !== ((k >= PressLat) ? ~exp_p : exp_p)) te++;
    end
    btn_pause = 1'b0;
    for (int k = 0; k < 12; k++) step();
    n_checks++;
    if (te != 0 || paused !== ~exp_p)
      $display("FAIL long_press got %0d errs p=%b want 0 p=%b", te, paused, ~exp_p);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    adj = 1'b0;
    while (blinkClk !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({minutes, seconds, paused, blinkClk, tick_1hz} !== 15'd0)
      $display("FAIL reset_mid got %0d:%0d p=%b b=%b t=%b want all 0",
               minutes, seconds, paused, blinkClk, tick_1hz);
    else n_pass++;
    @(negedge fastClk);
    reset = 1'b0;
    em = 0;
    es = 0;
    exp_q.delete();
  endtask

  task automatic test_adj_wrap();
    int err = 0;
    sel = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (tick_1hz !== 1'b0) err++;
    end
    adj = 1'b1;
    step();
    n_checks++;
    if (err != 0 || tick_1hz !== 1'b0 || {minutes, seconds} !== {6'd1, 6'd0})
      $display("FAIL adj_wins got %0d:%0d t=%b want 1:0 t=0", minutes, seconds, tick_1hz);
    else n_pass++;
    adj = 1'b0;
    step();
    n_checks++;
    if (tick_1hz !== 1'b1 || {minutes, seconds} !== {6'd1, 6'd1})
      $display("FAIL p1_held got %0d:%0d t=%b want 1:1 t=1", minutes, seconds, tick_1hz);
    else n_pass++;
    em = 1;
    es = 1;
  endtask

  task automatic test_press_wrap();
    int s = 10 - PressLat;
    int err = 0;
    logic [11:0] e;
    push_run(1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k < 10 && (paused !== 1'b0 || tick_1hz !== 1'b0)) err++;
      if (k == s) btn_pause = 1'b1;
    end
    n_checks++;
    e = exp_q.pop_front();
    if (err != 0 || tick_1hz !== 1'b1 || paused !== 1'b1 || {minutes, seconds} !== e)
      $display("FAIL press_wrap got %0d:%0d t=%b p=%b errs %0d want %0d:%0d t=1 p=1",
               minutes, seconds, tick_1hz, paused, err, e[11:6], e[5:0]);
    else n_pass++;
    err = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick_1hz !== 1'b0 || paused !== 1'b1 || {minutes, seconds} !== e) err++;
    end
    btn_pause = 1'b0;
    n_checks++;
    if (err != 0) $display("FAIL press_wrap_hold got %0d errs want 0", err);
    else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    btn_pause = 1'b0;
    adj       = 1'b0;
    sel       = 1'b0;
    test_reset();
    test_run();
    test_preload_wrap();
    test_adjust_fields();
    test_pause();
    test_debounce();
    test_reset_mid();
    test_adj_wrap();
    test_press_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
